// File: rtl/ripple_add_sequencer.sv
// Multi-precision add/subtract sequencer: drives one shared WIDTH-bit adder over NCHUNK
// chunks, LSB first, chaining the carry through a 1-bit register between cycles.
module ripple_add_sequencer #(
    parameter int WIDTH  = 8,
    parameter int NCHUNK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*NCHUNK-1:0]   in_a,
    input  logic [WIDTH*NCHUNK-1:0]   in_b,
    input  logic                      in_sub,
    input  logic                      in_cin,
    output logic [WIDTH-1:0]          adder_in0,
    output logic [WIDTH-1:0]          adder_in1,
    output logic                      adder_cin,
    input  logic [WIDTH-1:0]          adder_sum,
    input  logic                      adder_cout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*NCHUNK-1:0]   out_sum,
    output logic                      out_cout,
    output logic                      out_ovf,
    output logic [1:0]                state_dbg
);

    localparam int W  = WIDTH * NCHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and a raised out_valid holds until it is taken.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            sub_reg;
    logic            cin_reg;
    logic [CW-1:0]   cnt;
    logic            carry;

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        adder_in0 = '0;
        adder_in1 = '0;
        adder_cin = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                adder_in0 = a_reg[cnt*WIDTH +: WIDTH];
                adder_in1 = b_reg[cnt*WIDTH +: WIDTH];
                // Subtraction is A + ~B + 1, so the borrow-in enters inverted on chunk 0.
                adder_cin = (cnt == '0) ? (sub_reg ? ~cin_reg : cin_reg) : carry;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sub_reg  <= 1'b0;
            cin_reg  <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_reg   <= in_a;
                b_reg   <= in_sub ? ~in_b : in_b;
                sub_reg <= in_sub;
                cin_reg <= in_cin;
                cnt     <= '0;
                carry   <= 1'b0;
            end
            if (state == RUN) begin
                out_sum[cnt*WIDTH +: WIDTH] <= adder_sum;
                carry <= adder_cout;
                if (cnt == LAST) begin
                    cnt      <= '0;
                    out_cout <= adder_cout;
                    // Top chunk's sum MSB is the result sign; b_reg already holds ~B for sub.
                    out_ovf  <= (a_reg[W-1] == b_reg[W-1]) && (adder_sum[WIDTH-1] != a_reg[W-1]);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
